// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types and width defaults
//
// Purpose: fetch FSM state enum plus default address/instruction widths and
//          sequential PC step, shared by fetch, branch-enable and decode stages.
// Ports:   none (package).
package fetch_unit_pkg;

  localparam int DEF_ADDR_BITS  = 16;
  localparam int DEF_INSTR_BITS = 32;
  localparam int DEF_PC_STEP    = 4;

  // BOOT  : one idle cycle after reset release, no request.
  // FETCH : issue a request at pc whenever the buffer can accept a word.
  // WAIT  : request outstanding, held stable until acknowledged.
  // DRAIN : request outstanding but flushed by a branch; its data is dropped.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - one-entry instruction holding register (load/consume/flush)
//
// Purpose: holds one fetched word and its address for decode.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_load              capture i_load_data/i_load_pc, set valid
//   i_load_data/_pc     word and its address
//   i_consume           decode takes the entry (clears valid unless loading)
//   i_flush             branch flush, clears valid; beats load and consume
//   o_valid/o_data/o_pc buffered entry
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int INSTR_BITS = DEF_INSTR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [INSTR_BITS-1:0] i_load_data,
  input  logic [ADDR_BITS-1:0]  i_load_pc,
  input  logic                  i_consume,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [INSTR_BITS-1:0] o_data,
  output logic [ADDR_BITS-1:0]  o_pc
);

  logic                  r_valid;
  logic [INSTR_BITS-1:0] r_data;
  logic [ADDR_BITS-1:0]  r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      // A load in the same cycle as a consume replaces the old entry.
      r_valid <= 1'b1;
      r_data  <= i_load_data;
      r_pc    <= i_load_pc;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with pc, branch redirect and 1-entry buffer
//
// Purpose: fetches sequential instruction words from instruction memory,
//          redirects on branches, and presents one buffered word to decode.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   br_en, br_target        branch-taken pulse and redirect address
//   imem_req, imem_addr     memory request and address (held until ack)
//   imem_ack, imem_rdata    memory accept and same-cycle read data
//   instr_valid/instr/instr_pc  buffered word to decode
//   instr_ready             decode consumes the buffered word
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   ADDR_BITS    = DEF_ADDR_BITS,
  parameter int                   INSTR_BITS   = DEF_INSTR_BITS,
  parameter int                   PC_STEP      = DEF_PC_STEP,
  parameter logic [ADDR_BITS-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  br_en,
  input  logic [ADDR_BITS-1:0]  br_target,
  output logic                  imem_req,
  output logic [ADDR_BITS-1:0]  imem_addr,
  input  logic                  imem_ack,
  input  logic [INSTR_BITS-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [INSTR_BITS-1:0] instr,
  output logic [ADDR_BITS-1:0]  instr_pc,
  input  logic                  instr_ready
);

  localparam logic [ADDR_BITS-1:0] STEP = ADDR_BITS'(PC_STEP);

  fetch_state_e          r_state;
  logic [ADDR_BITS-1:0]  r_pc;
  logic [ADDR_BITS-1:0]  r_req_addr;

  fetch_state_e          w_state_nxt;
  logic [ADDR_BITS-1:0]  w_pc_nxt;
  logic [ADDR_BITS-1:0]  w_req_addr_nxt;
  logic                  w_req;
  logic [ADDR_BITS-1:0]  w_addr;
  logic                  w_load;
  logic [ADDR_BITS-1:0]  w_load_pc;
  logic                  w_buf_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VECTOR;
      r_req_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_addr_nxt = r_req_addr;
    w_req          = 1'b0;
    w_addr         = r_pc;
    w_load         = 1'b0;
    w_load_pc      = r_pc;

    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        // Only request when the buffer is free or being emptied this cycle,
        // so a returning word always has somewhere to go.
        w_req  = !w_buf_valid || instr_ready;
        w_addr = r_pc;
        if (w_req && !imem_ack) begin
          // Freeze the address so it stays stable until acknowledged.
          w_req_addr_nxt = r_pc;
          w_state_nxt    = br_en ? ST_DRAIN : ST_WAIT;
        end else if (w_req && !br_en) begin
          w_load   = 1'b1;
          w_load_pc = r_pc;
          w_pc_nxt = r_pc + STEP;
        end
      end

      ST_WAIT: begin
        w_req  = 1'b1;
        w_addr = r_req_addr;
        if (imem_ack) begin
          w_state_nxt = ST_FETCH;
          if (!br_en) begin
            w_load    = 1'b1;
            w_load_pc = r_req_addr;
            w_pc_nxt  = r_req_addr + STEP;
          end
        end else if (br_en) begin
          w_state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Keep the stale request alive until memory answers; drop its data.
        w_req  = 1'b1;
        w_addr = r_req_addr;
        if (imem_ack) begin
          w_state_nxt = ST_FETCH;
        end
      end

      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase

    // Branch redirect overrides any sequential pc update; last target wins.
    if (br_en) begin
      w_pc_nxt = br_target;
    end
  end

  fetch_buf #(
    .ADDR_BITS (ADDR_BITS),
    .INSTR_BITS(INSTR_BITS)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_data(imem_rdata),
    .i_load_pc  (w_load_pc),
    .i_consume  (instr_ready),
    .i_flush    (br_en),
    .o_valid    (w_buf_valid),
    .o_data     (instr),
    .o_pc       (instr_pc)
  );

  assign imem_req    = w_req;
  assign imem_addr   = w_addr;
  assign instr_valid = w_buf_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_en;
  logic [15:0] br_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] w;
  } exp_t;

  exp_t exp_q[$];

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_en      (br_en),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  initial forever #5 clk = ~clk;

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  // Program order expected by decode: start, start+4, ... (16-bit wrap).
  task automatic rebuild(input logic [15:0] start);
    exp_t e;
    logic [15:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 8; i++) begin
      e.pc = a;
      e.w  = mem_word(a);
      exp_q.push_back(e);
      a = a + 16'd4;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One cycle of stimulus: inputs at the falling edge, memory answers 1 later.
  task automatic step(input bit rst, input bit rdy, input bit br,
                      input logic [15:0] tgt, input bit ack);
    @(negedge clk);
    rst_n       = rst ? 1'b0 : 1'b1;
    instr_ready = rdy;
    br_en       = br;
    br_target   = tgt;
    if (rst) rebuild(16'h0000);
    else if (br) rebuild(tgt);
    #1;
    imem_ack   = ack;
    imem_rdata = ack ? mem_word(imem_addr) : $urandom;
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on every decode handshake.
  bit          prev_hold = 1'b0;
  bit          prev_br   = 1'b0;
  logic [15:0] hold_addr = 16'h0;
  exp_t        m_e;
  exp_t        m_n;

  always begin
    @(negedge clk);
    #3;
    if (rst_n === 1'b1) begin
      if (prev_hold) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_held", 32'(imem_addr), 32'(hold_addr));
      end
      if (prev_br) check("flush_valid", 32'(instr_valid), 32'd0);
      if (instr_valid && instr_ready && !br_en) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          check("instr_pc", 32'(instr_pc), 32'(m_e.pc));
          check("instr", instr, m_e.w);
          n_pop++;
          if (exp_q.size() > 0) begin
            m_n.pc = exp_q[$].pc + 16'd4;
            m_n.w  = mem_word(m_n.pc);
            exp_q.push_back(m_n);
          end
        end
      end
      prev_hold = imem_req && !imem_ack;
      hold_addr = imem_addr;
      prev_br   = br_en;
    end else begin
      prev_hold = 1'b0;
      prev_br   = 1'b0;
    end
  end

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    br_en       = 1'b0;
    br_target   = 16'h0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h0;
    rebuild(16'h0000);
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot_req", 32'(imem_req), 32'd0);

    // Streaming with ack and ready held high.
    step(0, 1, 0, 16'h0, 1); check("seq_a0", 32'(imem_addr), 32'h0000);
    check("seq_req", 32'(imem_req), 32'd1);
    step(0, 1, 0, 16'h0, 1); check("seq_a4", 32'(imem_addr), 32'h0004);
    check("seq_pc0", 32'(instr_pc), 32'h0000);
    step(0, 1, 0, 16'h0, 1); check("seq_a8", 32'(imem_addr), 32'h0008);
    check("seq_pc4", 32'(instr_pc), 32'h0004);
    step(0, 1, 0, 16'h0, 1); check("seq_ac", 32'(imem_addr), 32'h000C);

    // Ack withheld for three cycles at 0x0010.
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 16'h0, 0);
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", 32'(imem_addr), 32'h0010);
    end
    step(0, 1, 0, 16'h0, 1); check("stall_ack", 32'(imem_addr), 32'h0010);
    step(0, 1, 0, 16'h0, 1); check("stall_pc", 32'(instr_pc), 32'h0010);
    check("stall_valid", 32'(instr_valid), 32'd1);

    // Decode back-pressure.
    step(0, 0, 0, 16'h0, 1); check("bp_req", 32'(imem_req), 32'd0);
    check("bp_pc", 32'(instr_pc), 32'h0014);
    step(0, 0, 0, 16'h0, 1); check("bp_req2", 32'(imem_req), 32'd0);
    check("bp_hold", 32'(instr_pc), 32'h0014);
    step(0, 1, 0, 16'h0, 1); check("bp_resume", 32'(imem_addr), 32'h0018);
    step(0, 1, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 0); check("w_addr", 32'(imem_addr), 32'h0020);

    // Branch while waiting on 0x0020.
    step(0, 0, 1, 16'h0100, 0); check("br_wait", 32'(imem_addr), 32'h0020);
    step(0, 1, 0, 16'h0, 1); check("drain_addr", 32'(imem_addr), 32'h0020);
    check("drain_valid", 32'(instr_valid), 32'd0);
    step(0, 1, 0, 16'h0, 1); check("br_tgt", 32'(imem_addr), 32'h0100);
    check("br_nodata", 32'(instr_valid), 32'd0);
    step(0, 1, 0, 16'h0, 0); check("br_pc", 32'(instr_pc), 32'h0100);

    // Branch coinciding with ack.
    step(0, 0, 1, 16'h0200, 1); check("brack_addr", 32'(imem_addr), 32'h0104);
    step(0, 1, 0, 16'h0, 1); check("brack_tgt", 32'(imem_addr), 32'h0200);
    check("brack_valid", 32'(instr_valid), 32'd0);

    // pc wrap past the top of the address space.
    step(0, 0, 1, 16'hFFF8, 0); check("wrap_bp", 32'(imem_req), 32'd0);
    step(0, 1, 0, 16'h0, 1); check("wrap_a0", 32'(imem_addr), 32'hFFF8);
    step(0, 1, 0, 16'h0, 1); check("wrap_a1", 32'(imem_addr), 32'hFFFC);
    step(0, 1, 0, 16'h0, 1); check("wrap_a2", 32'(imem_addr), 32'h0000);
    step(0, 1, 0, 16'h0, 1); check("wrap_pc", 32'(instr_pc), 32'h0000);

    // Randomized traffic: stalls, back-pressure, branches, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      bit          rd;
      bit          b;
      bit          a;
      logic [15:0] t;
      if ($urandom_range(0, 499) == 0) begin
        for (int r = 0; r < 2; r++) begin
          step(1, $urandom_range(0, 1) == 1, 0, 16'h0, $urandom_range(0, 1) == 1);
          check("rrst_req", 32'(imem_req), 32'd0);
          check("rrst_valid", 32'(instr_valid), 32'd0);
        end
      end
      rd = $urandom_range(0, 3) != 0;
      b  = $urandom_range(0, 11) == 0;
      if (b) rd = 1'b0;
      t  = 16'($urandom) & 16'hFFFC;
      a  = $urandom_range(0, 2) != 0;
      step(0, rd, b, t, a);
    end

    step(0, 1, 0, 16'h0, 1);
    #3;
    check("pops", 32'(n_pop > 200), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
